// File: rtl/fetch_align_ctrl.sv
// Fetch alignment controller: word fetches into a 4-halfword queue, extracts
// 16/32-bit instructions at any halfword alignment, routes RVC through the decompressor.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [15:0] dec_in,
    input  logic [31:0] dec_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_compressed,
    output logic        instr_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t           state, state_nx;
    logic [3:0][15:0] q, q_sh, q_nx;
    logic [2:0]       count, count_nx, cnt_pop, pop_n;
    logic [31:0]      pc, pc_nx, fetch_addr, fetch_addr_nx;
    logic             skip, skip_nx;
    logic             head_cmp, pop, push, redir;
    logic [1:0]       wr_idx;
    logic             unused_ok;

    assign unused_ok = redirect_pc[0];

    // Head decode is purely combinational so the downstream sees zero added latency.
    assign head_cmp         = (q[0][1:0] != 2'b11);
    assign instr_valid      = head_cmp ? (count >= 3'd1) : (count >= 3'd2);
    assign dec_in           = q[0];
    assign instr_out        = head_cmp ? dec_out : {q[1], q[0]};
    assign instr_compressed = head_cmp;
    assign instr_illegal    = instr_valid && (q[0] == 16'h0000);
    assign instr_pc         = pc;
    assign imem_addr        = fetch_addr;

    assign pop     = instr_valid && instr_ready && !redirect_valid;
    assign pop_n   = pop ? (head_cmp ? 3'd1 : 3'd2) : 3'd0;
    assign cnt_pop = count - pop_n;
    assign wr_idx  = cnt_pop[1:0];

    always_comb begin
        case (pop_n)
            3'd1:    q_sh = {16'h0000, q[3], q[2], q[1]};
            3'd2:    q_sh = {16'h0000, 16'h0000, q[3], q[2]};
            default: q_sh = q;
        endcase
    end

    always_comb begin
        state_nx      = state;
        count_nx      = cnt_pop;
        pc_nx         = pc + {28'd0, pop_n, 1'b0};
        fetch_addr_nx = fetch_addr;
        skip_nx       = skip;
        q_nx          = q_sh;
        imem_req      = 1'b0;
        push          = 1'b0;
        redir         = 1'b0;

        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    redir = 1'b1;
                end else if (rst_n && cnt_pop <= 3'd2) begin
                    imem_req      = 1'b1;
                    fetch_addr_nx = fetch_addr + 32'd4;
                    state_nx      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    redir    = 1'b1;
                    state_nx = imem_rvalid ? S_IDLE : S_DISCARD;
                end else if (imem_rvalid) begin
                    push     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DISCARD: begin
                redir = redirect_valid;
                if (imem_rvalid) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Push lands behind what survives this cycle's pop; cnt_pop<=2 here so no overflow.
        if (push) begin
            if (skip) begin
                q_nx[wr_idx] = imem_rdata[31:16];
                count_nx     = cnt_pop + 3'd1;
            end else begin
                q_nx[wr_idx]        = imem_rdata[15:0];
                q_nx[wr_idx + 2'd1] = imem_rdata[31:16];
                count_nx            = cnt_pop + 3'd2;
            end
            skip_nx = 1'b0;
        end

        if (redir) begin
            count_nx      = 3'd0;
            pc_nx         = {redirect_pc[31:1], 1'b0};
            fetch_addr_nx = {redirect_pc[31:2], 2'b00};
            skip_nx       = redirect_pc[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= 3'd0;
            q          <= '0;
            pc         <= {RESET_PC[31:1], 1'b0};
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            skip       <= RESET_PC[1];
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            q          <= q_nx;
            pc         <= pc_nx;
            fetch_addr <= fetch_addr_nx;
            skip       <= skip_nx;
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Scoreboard bench for fetch_align_ctrl: expected instructions queued with stimulus,
// compared on every downstream accept; memory and decompressor are small bench models.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [15:0] dec_in;
    logic [31:0] dec_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_illegal;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_align_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_in(dec_in), .dec_out(dec_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_compressed(instr_compressed), .instr_illegal(instr_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expand(input logic [15:0] h);
        return {h ^ 16'hFFFF, h ^ 16'h5A5A};
    endfunction

    assign dec_out = expand(dec_in);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] hw;
        logic        cmp;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0, bad = 0;
    logic        rst_cmd = 1'b0, rdy = 1'b1, redir = 1'b0;
    logic [31:0] redir_pc = '0, last_addr = '0, resp_addr = '0;
    logic        resp_pend = 1'b0;
    int          resp_cnt = 0, lat = 1, req_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0001_0001;
    endfunction

    task automatic exp_c(input logic [31:0] pc, input logic [15:0] hw);
        exp_q.push_back('{pc: pc, instr: expand(hw), hw: hw, cmp: 1'b1, ill: (hw == 16'h0000)});
    endtask

    task automatic exp_w(input logic [31:0] pc, input logic [31:0] w);
        exp_q.push_back('{pc: pc, instr: w, hw: w[15:0], cmp: 1'b0, ill: 1'b0});
    endtask

    // One clock: drive inputs at negedge, sample settled outputs 1 unit later.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        rst_n = rst_cmd;
        if (!rst_cmd) begin
            resp_pend   = 1'b0;
            imem_rvalid = 1'b0;
        end else if (resp_pend && resp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_rd(resp_addr);
            resp_pend   = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (resp_pend) resp_cnt--;
        end
        instr_ready    = rdy && (exp_q.size() > 0);
        redirect_valid = redir && rst_cmd;
        redirect_pc    = redir_pc;
        redir          = 1'b0;
        #1;
        if (imem_req) begin
            req_cnt++;
            last_addr = imem_addr;
            resp_addr = imem_addr;
            resp_pend = 1'b1;
            resp_cnt  = lat - 1;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            e = exp_q.pop_front();
            chk("pc", instr_pc, e.pc);
            chk("instr", instr_out, e.instr);
            chk("cmp", {31'd0, instr_compressed}, {31'd0, e.cmp});
            chk("ill", {31'd0, instr_illegal}, {31'd0, e.ill});
            if (e.cmp) chk("dec_in", {16'd0, dec_in}, {16'd0, e.hw});
        end
    endtask

    task automatic do_reset();
        rst_cmd = 1'b0;
        rdy     = 1'b1;
        lat     = 1;
        mem.delete();
        cycle();
        cycle();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_vld", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", instr_pc, 32'h0);
        req_cnt = 0;
        rst_cmd = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;

        // Basic compressed pair
        do_reset();
        mem[32'h0] = 32'h0505_0505;
        exp_c(32'h0, 16'h0505);
        exp_c(32'h2, 16'h0505);
        cycle();
        chk("t1_req", req_cnt, 32'd1);
        chk("t1_addr", last_addr, 32'h0);
        drain();

        // 32-bit instruction straddling two words
        do_reset();
        mem[32'h0] = 32'h0013_0505;
        mem[32'h4] = 32'h0505_0000;
        exp_c(32'h0, 16'h0505);
        exp_w(32'h2, 32'h0000_0013);
        exp_c(32'h6, 16'h0505);
        drain();

        // Redirect in idle to an odd halfword
        do_reset();
        mem[32'h100] = 32'h1111_0505;
        exp_c(32'h102, 16'h1111);
        exp_c(32'h104, 16'h0001);
        redir = 1'b1; redir_pc = 32'h0000_0102;
        cycle();
        chk("t3_noreq", req_cnt, 32'd0);
        cycle();
        chk("t3_req", req_cnt, 32'd1);
        chk("t3_addr", last_addr, 32'h100);
        drain();

        // Redirect in wait, late response must be dropped
        do_reset();
        mem[32'h0]   = 32'h0101_0101;
        mem[32'h200] = 32'h0909_0505;
        exp_c(32'h200, 16'h0505);
        exp_c(32'h202, 16'h0909);
        lat = 3;
        cycle();
        lat = 1;
        redir = 1'b1; redir_pc = 32'h200;
        cycle();
        n = 0;
        while (req_cnt < 2 && n < 10) begin cycle(); n++; end
        chk("t4_gap", n, 32'd3);
        chk("t4_addr", last_addr, 32'h200);
        drain();

        // Redirect together with the response: straight back to idle
        do_reset();
        mem[32'h0]   = 32'h0101_0101;
        mem[32'h200] = 32'h0909_0505;
        exp_c(32'h200, 16'h0505);
        exp_c(32'h202, 16'h0909);
        cycle();
        redir = 1'b1; redir_pc = 32'h200;
        cycle();
        n = 0;
        while (req_cnt < 2 && n < 10) begin cycle(); n++; end
        chk("t4b_gap", n, 32'd1);
        chk("t4b_addr", last_addr, 32'h200);
        drain();

        // Downstream stall with an all-compressed stream
        do_reset();
        mem[32'h0] = 32'h2221_1111;
        mem[32'h4] = 32'h4441_3331;
        mem[32'h8] = 32'h6661_5551;
        mem[32'hC] = 32'h8881_7771;
        exp_c(32'h0, 16'h1111); exp_c(32'h2, 16'h2221);
        exp_c(32'h4, 16'h3331); exp_c(32'h6, 16'h4441);
        exp_c(32'h8, 16'h5551); exp_c(32'hA, 16'h6661);
        exp_c(32'hC, 16'h7771); exp_c(32'hE, 16'h8881);
        rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c >= 2) begin
                chk("t5_hold_pc", instr_pc, 32'h0);
                chk("t5_hold_out", instr_out, expand(16'h1111));
            end
            if (c >= 4) chk("t5_noreq", {31'd0, imem_req}, 32'd0);
        end
        chk("t5_reqs", req_cnt, 32'd2);
        rdy = 1'b1;
        drain();

        // Defined-illegal all-zero halfword
        do_reset();
        mem[32'h0] = 32'h0505_0000;
        exp_c(32'h0, 16'h0000);
        exp_c(32'h2, 16'h0505);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_align_ctrl.md
Name: fetch_align_ctrl

Overview:
- Instruction-fetch alignment controller between the instruction memory and the IF/ID pipeline register.
- Issues word-aligned fetches and buffers returned halfwords in a 4-entry halfword queue.
- Extracts 16-bit (RVC) or 32-bit instructions from any halfword alignment.
- Sequences the combinational decompression unit: each compressed halfword goes out on dec_in, and the expanded 32-bit word comes back on dec_out. Every instruction handed downstream is therefore a 32-bit RV32I encoding.

Parameters:
- RESET_PC, 32'h0000_0000: first instruction address after reset; bit 0 ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- imem_req  output  1  one-cycle fetch request pulse; memory always accepts it.
- imem_addr  output  32  fetch address; bits [1:0] always 2'b00.
- imem_rvalid  input  1  response valid; at least 1 cycle after imem_req.
- imem_rdata  input  32  fetched word; [15:0] = lower-address halfword.
- dec_in  output  16  halfword presented to the decompression unit.
- dec_out  input  32  decompressed instruction for dec_in (combinational).
- instr_valid  output  1  instruction available downstream.
- instr_ready  input  1  downstream accepts (low = stall).
- instr_out  output  32  32-bit instruction.
- instr_pc  output  32  address of instr_out.
- instr_compressed  output  1  instr_out originated from a 16-bit encoding.
- instr_illegal  output  1  head halfword is 16'h0000 (defined-illegal RVC).
- redirect_valid  input  1  branch/jump/flush redirect.
- redirect_pc  input  32  redirect target; bit 0 ignored.

Behaviour:
- Reset (rst_n low at clk edge):
  - queue count=0; state=S_IDLE.
  - fetch_addr={RESET_PC[31:2],2'b00}; skip=RESET_PC[1]; pc={RESET_PC[31:1],1'b0}.
  - imem_req=0; instr_valid=0.
  - Reset mid-transaction discards everything. A response arriving after reset is ignored: state is S_IDLE with no outstanding request, so imem_rvalid is ignored in S_IDLE.
- Queue: 4 halfword entries, head at index 0, count 0..4.
- Head decode (combinational, zero latency):
  - head[1:0]!=2'b11 → compressed. instr_valid=(count>=1); dec_in=head; instr_out=dec_out; instr_compressed=1.
  - Otherwise 32-bit. instr_valid=(count>=2); instr_out={entry1,entry0}; instr_compressed=0.
  - dec_in=head in all cases.
  - instr_illegal=instr_valid & (head==16'h0000).
  - instr_pc=pc.
- Pop occurs when instr_valid & instr_ready & !redirect_valid.
  - Compressed: pop 1 halfword, pc+=2. 32-bit: pop 2 halfwords, pc+=4.
  - pc wraps modulo 2^32.
- FSM:
  - S_IDLE:
    - If redirect_valid: apply redirect, stay.
    - Else if count_after_pop<=2: imem_req=1, imem_addr=fetch_addr, fetch_addr+=4, go S_WAIT.
  - S_WAIT:
    - If redirect_valid: apply redirect. Next state is S_IDLE if imem_rvalid this cycle (response dropped), else S_DISCARD.
    - Else if imem_rvalid: push {rdata[31:16],rdata[15:0]} (2 entries), or only rdata[31:16] if skip=1, then clear skip; go S_IDLE.
  - S_DISCARD:
    - imem_rvalid → drop data, go S_IDLE.
    - redirect_valid updates the redirect target; state is unchanged unless imem_rvalid is also set.
- Push and pop in the same cycle are both applied; pop uses pre-push contents.
- Overflow is impossible: a fetch issues only with count<=2, and only one request is ever outstanding.
- Apply redirect:
  - count=0; pc={redirect_pc[31:1],1'b0}.
  - fetch_addr={redirect_pc[31:2],2'b00}; skip=redirect_pc[1].
  - instr_valid is not suppressed in the redirect cycle, but no pop occurs.
- imem_req is never asserted in S_WAIT or S_DISCARD, or in the reset cycle.
- Throughput: at most one fetch per 2 cycles. This is acceptable by design.

Test Plan:
1. Reset with RESET_PC=0; memory returns 32'h0505_0505 at 0.
   - Required: imem_req at 0 in the first cycle after reset release.
   - Required: two outputs, instr_pc 0 then 2, dec_in=16'h0505, instr_compressed=1, instr_out=dec_out.
2. Word 0 = 32'h0013_0505, word 4 = 32'h0505_0000.
   - Required: c.addi at pc 0.
   - Required: instr_out=32'h0000_0013 at pc 2, instr_compressed=0, spanning two words.
   - Required: then compressed 16'h0505 at pc 6.
3. redirect_pc=32'h0000_0102 in S_IDLE.
   - Required: next imem_addr=0x100; lower halfword dropped; first instr_pc=0x102.
4. Redirect to 0x200 while in S_WAIT, response arriving 2 cycles later.
   - Required: response dropped; then imem_req at 0x200.
   - Required: no instruction from the old stream.
   - Repeat with redirect and imem_rvalid in the same cycle: required next state S_IDLE.
5. instr_ready=0 for 6 cycles with all-compressed stream.
   - Required: instr_out/instr_pc held stable; count never exceeds 4.
   - Required: imem_req low while count>2; stream resumes in order.
6. Halfword 16'h0000 at head.
   - Required: instr_valid=1, instr_illegal=1, instr_compressed=1, pc advances by 2 on accept.
